// File: rtl/mc_main_fsm.sv
// Multicycle RV32I main controller: steps each instruction through fetch, decode,
// execute, memory and writeback. It stalls on mem_ready and counts retired instructions.
module mc_main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_op,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_ir_write,
  output logic             o_adr_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_result_src,
  output logic             o_pc_write,
  output logic             o_reg_write,
  output logic             o_mem_write,
  output logic             o_mem_req,
  output logic             o_illegal_op,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } stateT;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  stateT            r_state;
  stateT            w_nextState;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  logic             w_illegal;
  logic             w_retire;
  logic             w_pcUpdate;
  logic             w_branch;

  // Reset wins over every transition, including a stalled memory access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_nextState;
      r_illegal <= w_illegal;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_nextState  = FETCH;
    w_illegal    = 1'b0;
    w_retire     = 1'b0;
    w_pcUpdate   = 1'b0;
    w_branch     = 1'b0;
    o_ir_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_result_src = 2'b00;
    o_reg_write  = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_req    = 1'b0;
    case (r_state)
      FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        w_pcUpdate   = i_mem_ready;
        w_nextState  = i_mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        case (i_op)
          OP_LW, OP_SW: w_nextState = MEMADR;
          OP_R:         w_nextState = EXECR;
          OP_I:         w_nextState = EXECI;
          OP_JAL:       w_nextState = JAL;
          OP_BEQ:       w_nextState = BEQ;
          default: begin
            w_nextState = FETCH;
            w_illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        w_nextState = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        o_adr_src   = 1'b1;
        o_mem_req   = 1'b1;
        w_nextState = i_mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        w_nextState = i_mem_ready ? FETCH : MEMWRITE;
        w_retire    = i_mem_ready;
      end
      EXECR: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b10;
        w_nextState = ALUWB;
      end
      EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b10;
        w_nextState = ALUWB;
      end
      ALUWB: begin
        o_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        w_pcUpdate  = 1'b1;
        w_nextState = ALUWB;
      end
      BEQ: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
      end
      default: w_nextState = FETCH;
    endcase
  end

  assign o_pc_write   = w_pcUpdate | (w_branch & i_zero);
  assign o_illegal_op = r_illegal;
  assign o_state      = r_state;
  assign o_retired    = r_retired;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Randomised bench for mc_main_fsm. It checks the controller against an
// instruction-path model on every cycle and adds a few literal scenario checks.
module tb_mc_main_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECR = 6, S_ALUWB = 7, S_EXECI = 8, S_JAL = 9, S_BEQ = 10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       irWrite;
    logic       adrSrc;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic [1:0] resultSrc;
    logic       pcWrite;
    logic       regWrite;
    logic       memWrite;
    logic       memReq;
  } ctrlT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'd0;
  logic        zero = 1'b0;
  logic        memReady = 1'b0;

  logic        irWrite, adrSrc, pcWrite, regWrite, memWrite, memReq, illegalOp;
  logic [1:0]  srcA, srcB, aluOp, resultSrc;
  logic [3:0]  stateO;
  logic [31:0] retired;

  logic        irWrite4, adrSrc4, pcWrite4, regWrite4, memWrite4, memReq4, illegalOp4;
  logic [1:0]  srcA4, srcB4, aluOp4, resultSrc4;
  logic [3:0]  stateO4;
  logic [3:0]  retired4;

  int          compared = 0;
  int          mismatched = 0;

  int          pathQ[$];
  logic [6:0]  curOp = 7'd0;
  logic [6:0]  nextOp = 7'd0;
  logic [31:0] retiredCnt = '0;
  bit          illegalExp = 1'b0;
  bit          modelValid = 1'b0;

  mc_main_fsm u_dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(memReady),
    .o_ir_write(irWrite), .o_adr_src(adrSrc), .o_alu_src_a(srcA), .o_alu_src_b(srcB),
    .o_alu_op(aluOp), .o_result_src(resultSrc), .o_pc_write(pcWrite),
    .o_reg_write(regWrite), .o_mem_write(memWrite), .o_mem_req(memReq),
    .o_illegal_op(illegalOp), .o_state(stateO), .o_retired(retired)
  );

  mc_main_fsm #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_zero(zero), .i_mem_ready(memReady),
    .o_ir_write(irWrite4), .o_adr_src(adrSrc4), .o_alu_src_a(srcA4), .o_alu_src_b(srcB4),
    .o_alu_op(aluOp4), .o_result_src(resultSrc4), .o_pc_write(pcWrite4),
    .o_reg_write(regWrite4), .o_mem_write(memWrite4), .o_mem_req(memReq4),
    .o_illegal_op(illegalOp4), .o_state(stateO4), .o_retired(retired4)
  );

  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_JAL) || (o == OP_BEQ);
  endfunction

  // Each instruction is described as the list of controller steps it visits.
  task automatic buildPath(input logic [6:0] o);
    pathQ.delete();
    pathQ.push_back(S_FETCH);
    pathQ.push_back(S_DECODE);
    case (o)
      OP_LW:   begin pathQ.push_back(S_MEMADR); pathQ.push_back(S_MEMREAD); pathQ.push_back(S_MEMWB); end
      OP_SW:   begin pathQ.push_back(S_MEMADR); pathQ.push_back(S_MEMWRITE); end
      OP_R:    begin pathQ.push_back(S_EXECR); pathQ.push_back(S_ALUWB); end
      OP_I:    begin pathQ.push_back(S_EXECI); pathQ.push_back(S_ALUWB); end
      OP_JAL:  begin pathQ.push_back(S_JAL); pathQ.push_back(S_ALUWB); end
      OP_BEQ:  pathQ.push_back(S_BEQ);
      default: ;
    endcase
  endtask

  function automatic ctrlT expectedCtrl(input int step, input bit ready, input bit z);
    ctrlT c;
    c = '0;
    case (step)
      S_FETCH:    begin c.memReq = 1; c.srcB = 2; c.resultSrc = 2; c.irWrite = ready; c.pcWrite = ready; end
      S_DECODE:   begin c.srcA = 1; c.srcB = 1; end
      S_MEMADR:   begin c.srcA = 2; c.srcB = 1; end
      S_MEMREAD:  begin c.adrSrc = 1; c.memReq = 1; end
      S_MEMWB:    begin c.resultSrc = 1; c.regWrite = 1; end
      S_MEMWRITE: begin c.adrSrc = 1; c.memReq = 1; c.memWrite = 1; end
      S_EXECR:    begin c.srcA = 2; c.srcB = 0; c.aluOp = 2; end
      S_EXECI:    begin c.srcA = 2; c.srcB = 1; c.aluOp = 2; end
      S_ALUWB:    begin c.regWrite = 1; end
      S_JAL:      begin c.srcA = 1; c.srcB = 2; c.pcWrite = 1; end
      S_BEQ:      begin c.srcA = 2; c.aluOp = 1; c.pcWrite = z; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    ctrlT e;
    if (!modelValid) return;
    e = expectedCtrl(pathQ[0], memReady, zero);
    compare("state",      64'(stateO),    64'(pathQ[0]));
    compare("state4",     64'(stateO4),   64'(pathQ[0]));
    compare("ir_write",   64'(irWrite),   64'(e.irWrite));
    compare("adr_src",    64'(adrSrc),    64'(e.adrSrc));
    compare("alu_src_a",  64'(srcA),      64'(e.srcA));
    compare("alu_src_b",  64'(srcB),      64'(e.srcB));
    compare("alu_op",     64'(aluOp),     64'(e.aluOp));
    compare("result_src", 64'(resultSrc), 64'(e.resultSrc));
    compare("pc_write",   64'(pcWrite),   64'(e.pcWrite));
    compare("reg_write",  64'(regWrite),  64'(e.regWrite));
    compare("mem_write",  64'(memWrite),  64'(e.memWrite));
    compare("mem_req",    64'(memReq),    64'(e.memReq));
    compare("illegal_op", 64'(illegalOp), 64'(illegalExp));
    compare("retired",    64'(retired),   64'(retiredCnt));
    compare("retired4",   64'(retired4),  64'(retiredCnt[3:0]));
  endtask

  // Drive one cycle's inputs, check the outputs, then advance the model across the edge.
  task automatic applyStimulus(input bit rstIn, input bit readyIn, input bit zeroIn);
    int  step;
    bit  stall;
    @(negedge clk);
    if (pathQ.size() == 0) begin
      curOp = nextOp;
      buildPath(curOp);
    end
    step     = pathQ[0];
    rst      = rstIn;
    memReady = readyIn;
    zero     = zeroIn;
    op       = (step == S_DECODE || step == S_MEMADR) ? curOp : 7'($urandom);
    #1;
    checkOutput();
    if (rstIn) begin
      pathQ.delete();
      retiredCnt = '0;
      illegalExp = 1'b0;
      modelValid = 1'b1;
    end else begin
      illegalExp = (step == S_DECODE) && !isLegal(curOp);
      stall = (step == S_FETCH || step == S_MEMREAD || step == S_MEMWRITE) && !readyIn;
      if (!stall) begin
        void'(pathQ.pop_front());
        if (pathQ.size() == 0 && isLegal(curOp)) retiredCnt = retiredCnt + 32'd1;
      end
    end
  endtask

  initial begin
    logic [6:0] opTable[8];

    // R-type with memory always ready
    nextOp = OP_R;
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0); compare("pin_r_s0", 64'(stateO), 64'd0);
    applyStimulus(0, 1, 0); compare("pin_r_s1", 64'(stateO), 64'd1);
    applyStimulus(0, 1, 0); compare("pin_r_s6", 64'(stateO), 64'd6); compare("pin_r_aluop", 64'(aluOp), 64'd2);
    applyStimulus(0, 1, 0); compare("pin_r_s7", 64'(stateO), 64'd7); compare("pin_r_rw", 64'(regWrite), 64'd1);
    applyStimulus(0, 1, 0); compare("pin_r_s0b", 64'(stateO), 64'd0); compare("pin_r_ret", 64'(retired), 64'd1);

    // Load stalled three cycles in MEMREAD
    nextOp = OP_LW;
    applyStimulus(1, 1, 0);
    repeat (3) applyStimulus(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i == 3, 0);
      compare("pin_lw_s3", 64'(stateO), 64'd3);
      compare("pin_lw_adr", 64'(adrSrc), 64'd1);
    end
    applyStimulus(0, 1, 0); compare("pin_lw_s4", 64'(stateO), 64'd4); compare("pin_lw_rw", 64'(regWrite), 64'd1);

    // Two branches, taken then not taken
    nextOp = OP_BEQ;
    applyStimulus(1, 1, 0);
    repeat (2) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1); compare("pin_beq_pc1", 64'(pcWrite), 64'd1); compare("pin_beq_op", 64'(aluOp), 64'd1);
    repeat (2) applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0); compare("pin_beq_pc0", 64'(pcWrite), 64'd0);
    applyStimulus(0, 1, 0); compare("pin_beq_ret", 64'(retired), 64'd2);

    // Unsupported opcode
    nextOp = 7'h7F;
    applyStimulus(1, 1, 0);
    repeat (2) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0); compare("pin_ill_s0", 64'(stateO), 64'd0); compare("pin_ill_p1", 64'(illegalOp), 64'd1);
    applyStimulus(0, 0, 0); compare("pin_ill_p0", 64'(illegalOp), 64'd0); compare("pin_ill_ret", 64'(retired), 64'd0);

    // Fetch stall, then reset during a stalled store
    nextOp = OP_SW;
    applyStimulus(1, 1, 0);
    repeat (5) begin
      applyStimulus(0, 0, 0);
      compare("pin_fs_irw", 64'(irWrite), 64'd0);
      compare("pin_fs_pcw", 64'(pcWrite), 64'd0);
      compare("pin_fs_s0", 64'(stateO), 64'd0);
    end
    repeat (3) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0); compare("pin_sw_mw1", 64'(memWrite), 64'd1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0); compare("pin_sw_s0", 64'(stateO), 64'd0); compare("pin_sw_mw0", 64'(memWrite), 64'd0);

    // Sixteen R-types wrap the narrow counter
    nextOp = OP_R;
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 1, 0);
      if (i == 60) compare("pin_wrap15", 64'(retired4), 64'd15);
    end
    applyStimulus(0, 1, 0);
    compare("pin_wrap0", 64'(retired4), 64'd0);
    compare("pin_wrap32", 64'(retired), 64'd16);

    // Random traffic with stalls, illegal ops and occasional resets
    opTable = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, 7'b0000000, 7'b1110011};
    for (int i = 0; i < 4000; i++) begin
      nextOp = opTable[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) nextOp = 7'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
